// File: rtl/wishbone_pkg.sv
// -----------------------------------------------------------------------------
// wishbone_pkg
// Shared definitions for the wishbone_master block:
//   - bus-width constants for address, data and byte-select
//   - FSM state enumeration
//   - lane helpers: 32-bit byte swap and 4-bit byte-select reversal that
//     convert between the little-endian host lanes and the big-endian
//     Wishbone lanes
// -----------------------------------------------------------------------------
package wishbone_pkg;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUS   = 2'd1,
    ST_RETRY = 2'd2,
    ST_RESP  = 2'd3
  } wb_state_e;

  // Byte 0 of the host word lands in the most significant Wishbone lane.
  function automatic logic [WB_DAT_W-1:0] byte_swap32(input logic [WB_DAT_W-1:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  // Byte enables follow the same lane reversal as the data.
  function automatic logic [WB_SEL_W-1:0] sel_rev4(input logic [WB_SEL_W-1:0] s);
    return {s[0], s[1], s[2], s[3]};
  endfunction

endpackage

// File: rtl/wishbone_master_if.sv
// -----------------------------------------------------------------------------
// wishbone_master_if
// Wishbone classic bus bundle between the host-side master and a slave.
// Signal names are seen from the master side (_o driven by the master,
// _i driven by the slave).
//   cyc_o, stb_o, we_o : cycle, strobe, write enable
//   adr_o              : byte address
//   sel_o, dat_o       : byte select / write data, big-endian lanes
//   dat_i              : read data, big-endian lanes
//   ack_i, err_i, rty_i: cycle terminations
// Modports: master (used by wishbone_master), slave (used by a responder).
// -----------------------------------------------------------------------------
interface wishbone_master_if;
  import wishbone_pkg::*;

  logic                cyc_o;
  logic                stb_o;
  logic                we_o;
  logic [WB_ADR_W-1:0] adr_o;
  logic [WB_SEL_W-1:0] sel_o;
  logic [WB_DAT_W-1:0] dat_o;
  logic [WB_DAT_W-1:0] dat_i;
  logic                ack_i;
  logic                err_i;
  logic                rty_i;

  modport master (
    output cyc_o, stb_o, we_o, adr_o, sel_o, dat_o,
    input  dat_i, ack_i, err_i, rty_i
  );

  modport slave (
    input  cyc_o, stb_o, we_o, adr_o, sel_o, dat_o,
    output dat_i, ack_i, err_i, rty_i
  );

endinterface

// File: rtl/wishbone_master.sv
// -----------------------------------------------------------------------------
// wishbone_master
// Turns single host requests (valid/ready) into Wishbone classic cycles and
// returns one response per request (valid/ready).
//
// Parameters
//   RETRY_LIMIT    : rty-terminated attempts retried before the request fails
//   TIMEOUT_CYCLES : BUS cycles without termination before abort
//
// Optional feature (compile-time macro WB_MASTER_TIMEOUT_EN)
//   defined   : a BUS-cycle counter aborts a silent cycle with err+timeout
//   undefined : BUS waits forever, rsp_timeout_o is tied low
//
// Ports
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   req_valid_i/ready_o : host request handshake (ready only in IDLE)
//   req_adr_i/we_i/sel_i/dat_i : host request, little-endian lanes
//   rsp_valid_o/ready_i : response handshake
//   rsp_dat_o           : read data in host lane order (0 for writes/errors)
//   rsp_err_o           : request failed (err, retry exhaustion or timeout)
//   rsp_timeout_o       : failure caused by timeout
//   wb                  : Wishbone classic bus (master modport)
// -----------------------------------------------------------------------------
module wishbone_master
  import wishbone_pkg::*;
#(
  parameter int RETRY_LIMIT    = 3,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,

  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [WB_ADR_W-1:0] req_adr_i,
  input  logic                req_we_i,
  input  logic [WB_SEL_W-1:0] req_sel_i,
  input  logic [WB_DAT_W-1:0] req_dat_i,

  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [WB_DAT_W-1:0] rsp_dat_o,
  output logic                rsp_err_o,
  output logic                rsp_timeout_o,

  wishbone_master_if.master   wb
);

  localparam int RETRY_W = (RETRY_LIMIT > 0) ? $clog2(RETRY_LIMIT + 1) : 1;

  wb_state_e           state_q, state_d;
  logic [RETRY_W-1:0]  retry_q, retry_d;
  logic [WB_ADR_W-1:0] adr_q, adr_d;
  logic                we_q, we_d;
  logic [WB_SEL_W-1:0] sel_q, sel_d;
  logic [WB_DAT_W-1:0] dat_q, dat_d;
  logic [WB_DAT_W-1:0] rsp_dat_q, rsp_dat_d;
  logic                rsp_err_q, rsp_err_d;
  logic                timeout_hit;   // last permitted BUS cycle elapsed

  // Ready is suppressed while reset is asserted so nothing is accepted then.
  assign req_ready_o = (state_q == ST_IDLE) && !rst_i;

  // ---------------------------------------------------------------------------
  // Optional BUS-cycle timeout
  // ---------------------------------------------------------------------------
`ifdef WB_MASTER_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            rsp_to_q, rsp_to_d;

  assign timeout_hit = (state_q == ST_BUS) && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  // Counter sits at zero outside BUS, so every entry into BUS (first attempt
  // or after a retry) starts a fresh window.
  always_comb begin
    to_cnt_d = to_cnt_q;
    rsp_to_d = rsp_to_q;
    if (state_q != ST_BUS) begin
      to_cnt_d = '0;
    end else if (!timeout_hit) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
    if (state_q == ST_IDLE) begin
      rsp_to_d = 1'b0;
    end else if (timeout_hit && !wb.err_i && !wb.ack_i && !wb.rty_i) begin
      rsp_to_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      to_cnt_q <= '0;
      rsp_to_q <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      rsp_to_q <= rsp_to_d;
    end
  end

  assign rsp_timeout_o = rsp_to_q;
`else
  assign timeout_hit   = 1'b0;
  assign rsp_timeout_o = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM next-state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    adr_d     = adr_q;
    we_d      = we_q;
    sel_d     = sel_q;
    dat_d     = dat_q;
    rsp_dat_d = rsp_dat_q;
    rsp_err_d = rsp_err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid_i && req_ready_o) begin
          adr_d     = req_adr_i;
          we_d      = req_we_i;
          sel_d     = req_sel_i;
          dat_d     = req_dat_i;
          retry_d   = '0;
          rsp_dat_d = '0;
          rsp_err_d = 1'b0;
          state_d   = ST_BUS;
        end
      end

      ST_BUS: begin
        // err outranks ack, which outranks rty.
        if (wb.err_i) begin
          rsp_err_d = 1'b1;
          rsp_dat_d = '0;
          state_d   = ST_RESP;
        end else if (wb.ack_i) begin
          rsp_err_d = 1'b0;
          rsp_dat_d = we_q ? '0 : byte_swap32(wb.dat_i);
          state_d   = ST_RESP;
        end else if (wb.rty_i) begin
          if (retry_q == RETRY_W'(RETRY_LIMIT)) begin
            rsp_err_d = 1'b1;
            rsp_dat_d = '0;
            state_d   = ST_RESP;
          end else begin
            retry_d = retry_q + RETRY_W'(1);
            state_d = ST_RETRY;
          end
        end else if (timeout_hit) begin
          rsp_err_d = 1'b1;
          rsp_dat_d = '0;
          state_d   = ST_RESP;
        end
      end

      // One idle bus cycle, then the latched request goes out again unchanged.
      ST_RETRY: state_d = ST_BUS;

      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      retry_q   <= '0;
      adr_q     <= '0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      dat_q     <= '0;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      retry_q   <= retry_d;
      adr_q     <= adr_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      dat_q     <= dat_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: cyc/stb decode straight from the state register so the
  // asynchronous reset drops them immediately.
  // ---------------------------------------------------------------------------
  assign wb.cyc_o    = (state_q == ST_BUS);
  assign wb.stb_o    = (state_q == ST_BUS);
  assign wb.we_o     = we_q;
  assign wb.adr_o    = adr_q;
  assign wb.sel_o    = sel_rev4(sel_q);
  assign wb.dat_o    = byte_swap32(dat_q);

  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_wishbone_master.sv
`timescale 1ns/1ps
module tb_wishbone_master;

  localparam int RETRY_LIMIT    = 3;
  localparam int TIMEOUT_CYCLES = 16;

  // Responder behaviour per attempt
  localparam int K_SILENT = 0;
  localparam int K_ACK    = 1;
  localparam int K_ERR    = 2;
  localparam int K_RTY    = 3;
  localparam int K_ERRACK = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_adr = '0;
  logic        req_we = 1'b0;
  logic [3:0]  req_sel = '0;
  logic [31:0] req_dat = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        rsp_timeout;

  wishbone_master_if wb ();

  wishbone_master #(
    .RETRY_LIMIT   (RETRY_LIMIT),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_adr_i    (req_adr),
    .req_we_i     (req_we),
    .req_sel_i    (req_sel),
    .req_dat_i    (req_dat),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_dat_o    (rsp_dat),
    .rsp_err_o    (rsp_err),
    .rsp_timeout_o(rsp_timeout),
    .wb           (wb)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model (lane mapping by streaming, outcome by walking the plan)
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] swap_model(input logic [31:0] x);
    return {<<8{x}};
  endfunction

  function automatic logic [3:0] rev_model(input logic [3:0] s);
    return {<<{s}};
  endfunction

  int          plan_kind [8];
  int          plan_lat  [8];
  logic [31:0] plan_dat  [8];
  int          exp_runs[$];   // expected cyc_o high-run lengths, one per attempt

  logic        rsp_expected = 1'b0;
  logic [31:0] exp_adr = '0, exp_dat_sw = '0, exp_rsp_dat = '0;
  logic [3:0]  exp_sel_sw = '0;
  logic        exp_we = 1'b0, exp_err = 1'b0, exp_to = 1'b0;

  function automatic void model_outcome(input logic we, input int n,
                                        output logic err, output logic to,
                                        output logic [31:0] d);
    int retries;
    retries = 0;
    err = 1'b0; to = 1'b0; d = '0;
    exp_runs.delete();
    for (int a = 0; a < n; a++) begin
      if (plan_kind[a] == K_SILENT) begin
        exp_runs.push_back(TIMEOUT_CYCLES);
        err = 1'b1; to = 1'b1;
        return;
      end
      exp_runs.push_back(plan_lat[a] + 1);
      if (plan_kind[a] == K_ERR || plan_kind[a] == K_ERRACK) begin
        err = 1'b1;
        return;
      end
      if (plan_kind[a] == K_ACK) begin
        d = we ? 32'h0 : swap_model(plan_dat[a]);
        return;
      end
      if (retries == RETRY_LIMIT) begin
        err = 1'b1;
        return;
      end
      retries++;
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Responder: terminates attempt r_att after plan_lat cycles of stb
  // ---------------------------------------------------------------------------
  int   r_cnt = 0;
  int   r_att = 0;
  logic spur_en = 1'b0;   // drive all terminations whenever no cycle is open

  always @(posedge clk) begin
    #1;
    if (rst || req_ready) begin
      r_cnt = 0;
      r_att = 0;
      wb.dat_i = '0;
      {wb.ack_i, wb.err_i, wb.rty_i} = spur_en ? 3'b111 : 3'b000;
    end else if (wb.cyc_o && wb.stb_o) begin
      r_cnt++;
      wb.dat_i = plan_dat[r_att];
      {wb.ack_i, wb.err_i, wb.rty_i} = 3'b000;
      if (r_cnt == plan_lat[r_att] + 1) begin
        case (plan_kind[r_att])
          K_ACK:    wb.ack_i = 1'b1;
          K_ERR:    wb.err_i = 1'b1;
          K_RTY:    wb.rty_i = 1'b1;
          K_ERRACK: begin wb.err_i = 1'b1; wb.ack_i = 1'b1; end
          default:  ;
        endcase
      end
    end else begin
      if (r_cnt != 0 && r_att < 7) r_att++;
      r_cnt = 0;
      {wb.ack_i, wb.err_i, wb.rty_i} = spur_en ? 3'b111 : 3'b000;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-cycle compare against the model
  // ---------------------------------------------------------------------------
  int   run_len = 0, gap_len = 0, runs_done = 0;
  logic prev_cyc = 1'b0, prev_rsp = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      run_len = 0; gap_len = 0; runs_done = 0;
      prev_cyc = 1'b0; prev_rsp = 1'b0;
      exp_runs.delete();
    end else begin
      check("stb_eq_cyc", {31'b0, wb.stb_o}, {31'b0, wb.cyc_o});
      if (wb.cyc_o) begin
        if (!prev_cyc && runs_done > 0) check("retry_gap", gap_len, 1);
        run_len++;
        gap_len = 0;
        check("adr_o", wb.adr_o, exp_adr);
        check("sel_o", {28'b0, wb.sel_o}, {28'b0, exp_sel_sw});
        check("dat_o", wb.dat_o, exp_dat_sw);
        check("we_o", {31'b0, wb.we_o}, {31'b0, exp_we});
        check("ready_in_bus", {31'b0, req_ready}, 32'd0);
      end else begin
        if (prev_cyc) begin
          if (exp_runs.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL cyc_run: got unexpected cyc_o run of %0d cycles, required none", run_len);
          end else begin
            check("cyc_run_len", run_len, exp_runs.pop_front());
          end
          runs_done++;
          run_len = 0;
        end
        gap_len++;
      end
      if (rsp_valid) begin
        if (!rsp_expected) begin
          n_checks++; n_fail++;
          $display("FAIL rsp_unexpected: got rsp_valid_o=1 required 0 at %0t", $time);
        end else begin
          check("rsp_dat", rsp_dat, exp_rsp_dat);
          check("rsp_err", {31'b0, rsp_err}, {31'b0, exp_err});
          check("rsp_timeout", {31'b0, rsp_timeout}, {31'b0, exp_to});
          check("ready_in_resp", {31'b0, req_ready}, 32'd0);
          if (!prev_rsp) begin
            check("attempts_left", exp_runs.size(), 0);
            runs_done = 0;
          end
        end
      end
      prev_cyc = wb.cyc_o;
      prev_rsp = rsp_valid;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  logic [31:0] got_dat;
  logic        got_err, got_to;

  task automatic set_plan(input int i, input int k, input int l, input logic [31:0] d);
    plan_kind[i] = k;
    plan_lat[i]  = l;
    plan_dat[i]  = d;
  endtask

  task automatic prep(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                      input logic [31:0] dat);
    exp_adr    = adr;
    exp_we     = we;
    exp_sel_sw = rev_model(sel);
    exp_dat_sw = swap_model(dat);
  endtask

  task automatic issue(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                       input logic [31:0] dat);
    @(posedge clk); #1;
    req_valid = 1'b1; req_adr = adr; req_we = we; req_sel = sel; req_dat = dat;
    @(negedge clk);
    check("req_ready_idle", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    // Scramble the host inputs so the bus must come from latched values.
    req_valid = 1'b0; req_adr = ~adr; req_we = ~we; req_sel = ~sel; req_dat = ~dat;
  endtask

  task automatic run_txn(input string tag, input logic [31:0] adr, input logic we,
                         input logic [3:0] sel, input logic [31:0] dat,
                         input int nplan, input int rsp_delay);
    logic e, t;
    logic [31:0] d;
    int waited;
    prep(adr, we, sel, dat);
    model_outcome(we, nplan, e, t, d);
    exp_err = e; exp_to = t; exp_rsp_dat = d;
    rsp_expected = 1'b1;
    issue(adr, we, sel, dat);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!rsp_valid && waited < 200);
    n_checks++;
    if (!rsp_valid) begin
      n_fail++;
      $display("FAIL %s_rsp_wait: got no rsp_valid_o in %0d cycles, required a response", tag, waited);
    end
    got_dat = rsp_dat; got_err = rsp_err; got_to = rsp_timeout;
    repeat (rsp_delay) @(negedge clk);
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    rsp_expected = 1'b0;
    $display("txn %-10s adr=0x%08h we=%0d sel=%b dat=0x%08h -> rsp_dat=0x%08h err=%0d timeout=%0d",
             tag, adr, we, sel, dat, got_dat, got_err, got_to);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    for (int i = 0; i < 8; i++) set_plan(i, K_SILENT, 1, 32'h0);

    repeat (3) @(negedge clk);
    check("rst_cyc", {31'b0, wb.cyc_o}, 32'd0);
    check("rst_stb", {31'b0, wb.stb_o}, 32'd0);
    check("rst_we", {31'b0, wb.we_o}, 32'd0);
    check("rst_adr", wb.adr_o, 32'd0);
    check("rst_sel", {28'b0, wb.sel_o}, 32'd0);
    check("rst_dat", wb.dat_o, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    check("rst_rsp_timeout", {31'b0, rsp_timeout}, 32'd0);
    check("rst_rsp_dat", rsp_dat, 32'd0);
    check("rst_req_ready", {31'b0, req_ready}, 32'd0);

    // Pin the model's lane mapping to hand-computed values.
    check("model_swap", swap_model(32'h7856_3412), 32'h1234_5678);
    check("model_rev", {28'b0, rev_model(4'b0011)}, {28'b0, 4'b1100});

    @(posedge clk); #1 rst = 1'b0;

    // Read, ack one cycle after stb
    set_plan(0, K_ACK, 1, 32'h7856_3412);
    run_txn("read_ack", 32'h0000_0004, 1'b0, 4'hF, 32'h0, 1, 0);
    check("lit_read_dat", got_dat, 32'h1234_5678);
    check("lit_read_err", {31'b0, got_err}, 32'd0);

    // Write with partial byte enables
    set_plan(0, K_ACK, 2, 32'h5555_AAAA);
    run_txn("write", 32'h0000_0010, 1'b1, 4'b0011, 32'hAABB_CCDD, 1, 1);
    check("lit_write_dat_o", exp_dat_sw, 32'hDDCC_BBAA);
    check("lit_write_sel_o", {28'b0, exp_sel_sw}, {28'b0, 4'b1100});
    check("lit_write_rsp_dat", got_dat, 32'd0);

    // rty, rty, ack
    set_plan(0, K_RTY, 1, 32'h0);
    set_plan(1, K_RTY, 2, 32'h0);
    set_plan(2, K_ACK, 1, 32'hCAFE_F00D);
    run_txn("rty2_ack", 32'h0000_0020, 1'b0, 4'hF, 32'h0, 3, 0);
    check("lit_rty2_dat", got_dat, 32'h0DF0_FECA);
    check("lit_rty2_err", {31'b0, got_err}, 32'd0);

    // Four rty: retries exhausted
    for (int i = 0; i < 4; i++) set_plan(i, K_RTY, 1, 32'h0);
    run_txn("rty4_fail", 32'h0000_0030, 1'b1, 4'b1000, 32'h0102_0304, 4, 0);
    check("lit_rty4_err", {31'b0, got_err}, 32'd1);

    // err and ack together
    set_plan(0, K_ERRACK, 1, 32'h1234_5678);
    run_txn("err_ack", 32'h0000_0040, 1'b0, 4'hF, 32'h0, 1, 0);
    check("lit_errack_err", {31'b0, got_err}, 32'd1);
    check("lit_errack_dat", got_dat, 32'd0);

    // Terminations driven while no cycle is open must be ignored
    spur_en = 1'b1;
    set_plan(0, K_ACK, 3, 32'h0102_0304);
    run_txn("spurious", 32'h0000_0050, 1'b0, 4'b0110, 32'h0, 1, 4);
    check("lit_spur_dat", got_dat, 32'h0403_0201);
    spur_en = 1'b0;

    // err alone, terminated in the first bus cycle
    set_plan(0, K_ERR, 0, 32'hFFFF_FFFF);
    run_txn("err_fast", 32'h0000_0060, 1'b1, 4'b0001, 32'h89AB_CDEF, 1, 0);
    check("lit_err_err", {31'b0, got_err}, 32'd1);

    // Silent responder
    set_plan(0, K_SILENT, 1, 32'h0);
`ifdef WB_MASTER_TIMEOUT_EN
    run_txn("timeout", 32'h0000_0070, 1'b0, 4'hF, 32'h0, 1, 0);
    check("lit_to_err", {31'b0, got_err}, 32'd1);
    check("lit_to_flag", {31'b0, got_to}, 32'd1);
    prep(32'h0000_0080, 1'b0, 4'hF, 32'h0);
    exp_runs.delete();
    issue(32'h0000_0080, 1'b0, 4'hF, 32'h0);
    repeat (3) @(negedge clk);
`else
    prep(32'h0000_0080, 1'b0, 4'hF, 32'h0);
    exp_runs.delete();
    issue(32'h0000_0080, 1'b0, 4'hF, 32'h0);
    repeat (1000) @(negedge clk);
    check("hang_cyc_1000", {31'b0, wb.cyc_o}, 32'd1);
    $display("txn %-10s adr=0x%08h cyc_o=%0d after 1000 cycles", "hang", 32'h80, wb.cyc_o);
`endif

    // Reset pulsed mid-BUS
    @(posedge clk); #3 rst = 1'b1;
    #1;
    check("async_rst_cyc", {31'b0, wb.cyc_o}, 32'd0);
    check("async_rst_stb", {31'b0, wb.stb_o}, 32'd0);
    @(posedge clk); @(posedge clk); #3 rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("no_rsp_after_rst", {31'b0, rsp_valid}, 32'd0);
    end
    $display("txn %-10s reset pulsed during BUS", "reset");

    // Normal traffic afterwards
    set_plan(0, K_ACK, 1, 32'hEFBE_ADDE);
    run_txn("post_rst", 32'h0000_0090, 1'b0, 4'hF, 32'h0, 1, 0);
    check("lit_post_dat", got_dat, 32'hDEAD_BEEF);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/wishbone_master.md
WISHBONE_MASTER -- requirements
Module: wishbone_master

Interface
REQ-001 SHALL have parameter RETRY_LIMIT, default 3: number of rty-terminated attempts retried before the request fails.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16: number of BUS-state cycles without termination before abort (used only with WB_MASTER_TIMEOUT_EN).
REQ-003 SHALL use one clock and an asynchronous, active-high reset, with the following ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- req_valid_i  in  1  request offered
- req_ready_o  out  1  request accepted when high with req_valid_i
- req_adr_i  in  32  byte address
- req_we_i  in  1  1=write, 0=read
- req_sel_i  in  4  host byte enables (bit0 = bits 7:0)
- req_dat_i  in  32  host write data, little-endian lanes
- rsp_valid_o  out  1  response available
- rsp_ready_i  in  1  response consumed when high with rsp_valid_o
- rsp_dat_o  out  32  read data, host lane order
- rsp_err_o  out  1  request failed
- rsp_timeout_o  out  1  failure caused by timeout
- cyc_o, stb_o, we_o  out  1 each  Wishbone classic cycle, strobe, write enable
- adr_o  out  32  Wishbone address
- sel_o  out  4  Wishbone byte select, big-endian lanes
- dat_o  out  32  Wishbone write data, big-endian lanes
- dat_i  in  32  Wishbone read data, big-endian lanes
- ack_i, err_i, rty_i  in  1 each  Wishbone cycle terminations

Function
REQ-004 SHALL implement states IDLE, BUS, RETRY, RESP; req_ready_o = 1 only in IDLE.
REQ-005 IDLE: on req_valid_i & req_ready_o, SHALL latch adr/we/sel/dat, clear the retry counter and enter BUS; cyc_o/stb_o rise on that same edge.
REQ-006 BUS: cyc_o, stb_o, adr_o, sel_o, we_o and dat_o SHALL be held stable until a termination is sampled.
REQ-007 Lane swap: dat_o = {req_dat[7:0], req_dat[15:8], req_dat[23:16], req_dat[31:24]}; sel_o = bit-reversed req_sel; rsp_dat_o = dat_i byte-swapped the same way.
REQ-008 Termination priority when several are sampled in one cycle: err_i > ack_i > rty_i.
REQ-009 On ack_i: SHALL enter RESP; cyc_o/stb_o fall and rsp_valid_o rises on the sampling edge; rsp_dat_o = swapped dat_i for reads and 0 for writes; rsp_err_o = 0.
REQ-010 On err_i: SHALL enter RESP with rsp_err_o = 1 and rsp_dat_o = 0.
REQ-011 On rty_i with retry count < RETRY_LIMIT: SHALL increment the count and enter RETRY (cyc_o/stb_o low for exactly one cycle), then return to BUS with an identical request.
REQ-012 On rty_i with count = RETRY_LIMIT: SHALL enter RESP with rsp_err_o = 1.
REQ-013 RESP: rsp_* SHALL be held until rsp_ready_i is high, then the block enters IDLE; no request is accepted in the same cycle.
REQ-014 Termination inputs SHALL be ignored outside BUS.

Reset
REQ-015 While rst_i is high: state IDLE; cyc_o, stb_o, we_o, rsp_valid_o, rsp_err_o and rsp_timeout_o = 0; adr_o, sel_o, dat_o and rsp_dat_o = 0; counters = 0; no request accepted.
REQ-016 Reset during BUS SHALL drop cyc_o/stb_o asynchronously; no response for the aborted request is produced after release.

Configuration
REQ-017 With WB_MASTER_TIMEOUT_EN defined: a BUS-cycle counter (cleared on entering BUS) reaching TIMEOUT_CYCLES SHALL force RESP with rsp_err_o = 1 and rsp_timeout_o = 1.
REQ-018 Without WB_MASTER_TIMEOUT_EN: BUS SHALL wait indefinitely; rsp_timeout_o is tied to 0 and no timeout counter is present.

Structure
REQ-019 Package wishbone_pkg SHALL hold the state enum, the 32-bit byte-swap and 4-bit sel-reverse functions, and the bus-width constants.
REQ-020 There SHALL be no sub-module; the block is a single FSM with its counters.

Verification
REQ-021 Read at adr 0x0000_0004, responder acks one cycle after stb with dat_i = 0x7856_3412 -> rsp_dat_o = 0x1234_5678, rsp_err_o = 0, cyc_o high for 2 cycles.
REQ-022 Write at adr 0x10 with dat 0xAABB_CCDD, sel 4'b0011 -> dat_o = 0xDDCC_BBAA, sel_o = 4'b1100, we_o = 1; rsp_dat_o = 0.
REQ-023 RETRY_LIMIT = 3: rty twice then ack -> single response with rsp_err_o = 0 and two one-cycle cyc_o gaps; rty four times -> rsp_err_o = 1 after the 4th rty.
REQ-024 err_i and ack_i high in the same cycle -> rsp_err_o = 1, rsp_dat_o = 0.
REQ-025 Macro defined, TIMEOUT_CYCLES = 16, responder silent -> cyc_o falls after 16 cycles with rsp_err_o = rsp_timeout_o = 1; macro undefined -> cyc_o still high after 1000 cycles.
REQ-026 rst_i pulsed mid-BUS -> cyc_o/stb_o low before the next edge; no rsp_valid_o after release; the next request completes normally.
